// File: rtl/alu_operand_sequencer.sv
// Operand capture sequencer: one "enter" button walks op1 -> op2 -> ALU control -> done,
// "back" undoes one step, and a completion counter tracks finished captures.
module alu_operand_sequencer #(
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  val,
  input  logic              enter,
  input  logic              back,
  output logic [WIDTH-1:0]  op1,
  output logic [WIDTH-1:0]  op2,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [1:0]        state,
  output logic              ops_valid,
  output logic              done_pulse,
  output logic [WIDTH-1:0]  disp,
  output logic [CNT_W-1:0]  txn_count
);

  typedef enum logic [1:0] {
    S_OP1  = 2'd0,
    S_OP2  = 2'd1,
    S_CTRL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t st;
  logic   enter_q;
  logic   back_q;
  logic   enter_e;
  logic   back_e;

  // Button history keeps sampling through reset so a held button cannot fire on release.
  always_ff @(posedge clk) begin
    enter_q <= enter;
    back_q  <= back;
  end

  assign enter_e = enter & ~enter_q;
  assign back_e  = back  & ~back_q;

  // Single FSM register block; back wins over enter when both rise together.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_OP1;
      ops_valid  <= 1'b0;
      done_pulse <= 1'b0;
      op1        <= '0;
      op2        <= '0;
      alu_ctrl   <= '0;
      txn_count  <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (back_e) begin
        case (st)
          S_OP2: begin
            st        <= S_OP1;
            ops_valid <= 1'b0;
          end
          S_CTRL: begin
            st        <= S_OP2;
            ops_valid <= 1'b0;
          end
          S_DONE: begin
            st        <= S_CTRL;
            ops_valid <= 1'b0;
          end
          default: begin
            st        <= S_OP1;
            ops_valid <= 1'b0;
          end
        endcase
      end else if (enter_e) begin
        case (st)
          S_OP1: begin
            op1       <= val;
            st        <= S_OP2;
            ops_valid <= 1'b0;
          end
          S_OP2: begin
            op2       <= val;
            st        <= S_CTRL;
            ops_valid <= 1'b0;
          end
          S_CTRL: begin
            alu_ctrl   <= val[CTRL_W-1:0];
            st         <= S_DONE;
            ops_valid  <= 1'b1;
            done_pulse <= 1'b1;
            txn_count  <= txn_count + 1'b1;
          end
          default: begin
            st        <= S_OP1;
            ops_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = st;

  // Display follows the switches while editing, and shows the first operand once complete.
  always_comb begin
    disp = val;
    case (st)
      S_CTRL:  disp = {{(WIDTH-CTRL_W){1'b0}}, val[CTRL_W-1:0]};
      S_DONE:  disp = op1;
      default: disp = val;
    endcase
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Parametrised successor to the three-register ALU operand bank.
- Replaces three independent retain buttons with one "enter" button and an FSM that captures op1, op2 and the ALU control word in order from a shared switch bus.
- Adds edge detection, single-step undo, a completion strobe, a live display mux and a transaction counter.
- Sits between the debounced board inputs (switches, buttons) and the ALU/display path.

Parameters:
- WIDTH, 16, width of switch bus, op1 and op2.
- CTRL_W, 4, width of ALU control word; taken from val[CTRL_W-1:0]; requires CTRL_W <= WIDTH.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- val  in  WIDTH  switch value to be captured.
- enter  in  1  debounced level button; acts on its rising edge only.
- back  in  1  debounced level button; acts on its rising edge only (undo one step).
- op1  out  WIDTH  captured operand 1.
- op2  out  WIDTH  captured operand 2.
- alu_ctrl  out  CTRL_W  captured ALU control word.
- state  out  2  FSM state for LEDs: 0=S_OP1, 1=S_OP2, 2=S_CTRL, 3=S_DONE.
- ops_valid  out  1  high while in S_DONE.
- done_pulse  out  1  one-cycle strobe on entry to S_DONE.
- disp  out  WIDTH  value for the 7-segment display.
- txn_count  out  CNT_W  number of completed captures.

Behaviour:
- One clock, clk. rst is synchronous and active-high and overrides everything.
- Reset values:
  - op1, op2, alu_ctrl, txn_count = 0.
  - state = S_OP1; ops_valid = 0; done_pulse = 0.
  - During rst, enter_q <= enter and back_q <= back. A button held through reset therefore does not fire on release of rst.
- Edge detection:
  - enter_e = enter & ~enter_q; back_e = back & ~back_q.
  - enter_q and back_q update every cycle.
  - Holding a button produces exactly one event.
- Priority: rst > back_e > enter_e. If both edges occur in the same cycle, only back acts.
- Latency: an event sampled at clock edge k updates registers and state at edge k. The new values are visible in the cycle after edge k.
- Transitions on enter_e:
  - S_OP1: op1 <= val; go to S_OP2.
  - S_OP2: op2 <= val; go to S_CTRL.
  - S_CTRL: alu_ctrl <= val[CTRL_W-1:0]; go to S_DONE; done_pulse <= 1 for one cycle; txn_count <= txn_count+1, wrapping modulo 2^CNT_W.
  - S_DONE: go to S_OP1. op1, op2 and alu_ctrl keep their values until overwritten.
- Transitions on back_e:
  - S_OP2 -> S_OP1; S_CTRL -> S_OP2; S_DONE -> S_CTRL.
  - S_OP1: no effect.
  - back never alters op1, op2 or alu_ctrl. Leaving S_DONE via back does not change txn_count.
- ops_valid = (state == S_DONE), registered consistently with state.
- done_pulse is never high for two consecutive cycles.
- disp (combinational from state, op registers and val):
  - S_OP1, S_OP2: shows live val.
  - S_CTRL: shows val with bits above CTRL_W zeroed.
  - S_DONE: shows op1.
- No event causes an output to glitch outside a clock edge, except disp following val.

Test Plan:
- Reset with enter held high, release rst, then release enter -> no capture; state=0; op1=op2=alu_ctrl=0; txn_count=0.
- val=0x1234, pulse enter; val=0x00FF, pulse enter; val=0xFFF3, pulse enter -> op1=0x1234, op2=0x00FF, alu_ctrl=0x3, state=3, ops_valid=1, done_pulse high exactly one cycle, txn_count=1.
- Hold enter for 10 cycles in S_OP1 with val=0xAAAA -> single capture: op1=0xAAAA, state=1 (not 2).
- From S_CTRL pulse back, set val=0x5555, pulse enter -> op2=0x5555, state=2, op1 unchanged. Then enter and back rise in the same cycle -> state=1, no capture.
- 256 complete capture sequences with CNT_W=8 -> txn_count wraps to 0; done_pulse count = 256.
- Assert rst for one cycle while in S_CTRL -> next cycle all outputs equal reset values, state=0.
